instr_encode: RTL and testbench

- Inverse of the decode-stage field parser: accepts decoded LEGv8 instruction fields plus a format select, and packs them into 32-bit instruction words.
- Streams the words out over a valid/ready handshake, each tagged with a sequential instruction-memory write address.
- Used by the bench infrastructure and the imem loader to build programs without hand-typing binary words.
- Registered pipeline stage with an address counter and a RUN/FULL state machine.

---
 rtl/instr_encode_pkg.sv | 25 ++
 rtl/instr_pack.sv | 28 ++
 rtl/instr_encode.sv | 72 +++++++
 tb/tb_instr_encode.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/instr_encode_pkg.sv
// instr_encode_pkg: format codes, FSM states, instruction length and LEGv8 opcode constants
package instr_encode_pkg;
    localparam int INSTR_LEN = 32;
    localparam int CYCLE = 10;
    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_B  = 3'd3,
        FMT_CB = 3'd4
    } fmt_e;
    typedef enum logic {
        RUN  = 1'b0,
        FULL = 1'b1
    } state_e;
    localparam int RD_LSB = 0;
    localparam int RN_LSB = 5;
    localparam int SHAMT_LSB = 10;
    localparam int RM_LSB = 16;
    localparam int OP_LSB = 21;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational fmt+fields -> 32-bit word; ports fmt/opcode/rm_num/rn_num/rd_num/shamt/address/imm in, word/illegal out
module instr_pack
    import instr_encode_pkg::*;
(
    input  logic [2:0]           fmt,
    input  logic [10:0]          opcode,
    input  logic [4:0]           rm_num,
    input  logic [4:0]           rn_num,
    input  logic [4:0]           rd_num,
    input  logic [5:0]           shamt,
    input  logic [8:0]           address,
    input  logic [25:0]          imm,
    output logic [INSTR_LEN-1:0] word,
    output logic                 illegal
);
    always_comb begin
        word = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R:   word = {opcode, rm_num, shamt, rn_num, rd_num};
            FMT_I:   word = {opcode[10:1], imm[11:0], rn_num, rd_num};
            FMT_D:   word = {opcode, address, imm[1:0], rn_num, rd_num};
            FMT_B:   word = {opcode[10:5], imm};
            FMT_CB:  word = {opcode[10:3], imm[18:0], rd_num};
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_encode.sv
// instr_encode: registered packer streaming words with imem addresses; ports clk/rst_n/clear, in_valid/in_ready+fields, out_valid/out_ready/instruction/wr_addr, full/err_sticky
module instr_encode
    import instr_encode_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [10:0]          opcode,
    input  logic [4:0]           rm_num,
    input  logic [4:0]           rn_num,
    input  logic [4:0]           rd_num,
    input  logic [5:0]           shamt,
    input  logic [8:0]           address,
    input  logic [25:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_LEN-1:0] instruction,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 full,
    output logic                 err_sticky
);
    state_e state, state_d;
    logic [INSTR_LEN-1:0] word;
    logic illegal, accept, out_hs, last;
    instr_pack u_pack (
        .fmt(fmt), .opcode(opcode), .rm_num(rm_num), .rn_num(rn_num), .rd_num(rd_num),
        .shamt(shamt), .address(address), .imm(imm), .word(word), .illegal(illegal)
    );
    assign in_ready = !clear && state == RUN && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign last = wr_addr == ADDR_W'(DEPTH - 1);
    assign full = state == FULL;
    always_comb begin
        state_d = state;
        state_d = clear ? RUN : (state == RUN && out_hs && last) ? FULL : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            out_valid <= 1'b0;
            instruction <= '0;
            wr_addr <= '0;
            err_sticky <= 1'b0;
        end else begin
            state <= state_d;
            if (clear) begin
                out_valid <= 1'b0;
                wr_addr <= '0;
                err_sticky <= 1'b0;
            end else begin
                if (out_hs)
                    wr_addr <= last ? '0 : wr_addr + 1'b1;
                if (accept) begin
                    out_valid <= !illegal;
                    if (!illegal)
                        instruction <= word;
                    if (illegal)
                        err_sticky <= 1'b1;
                end else if (out_hs) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encode.sv
// tb_instr_encode: directed self-checking bench for instr_encode with DEPTH=4
module tb_instr_encode;
    import instr_encode_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, full, err_sticky;
    logic [2:0] fmt = '0;
    logic [10:0] opcode = '0;
    logic [4:0] rm_num = '0, rn_num = '0, rd_num = '0;
    logic [5:0] shamt = '0;
    logic [8:0] address = '0;
    logic [25:0] imm = '0;
    logic [31:0] instruction;
    logic [1:0] wr_addr;
    int checks = 0, failures = 0;

    localparam logic [31:0] W_LDUR = 32'hF84F0149;
    localparam logic [31:0] W_ADD  = 32'h8B0902A9;
    localparam logic [31:0] W_ADDI = 32'h910006A9;
    localparam logic [31:0] W_STUR = 32'hF8000043;
    localparam logic [31:0] W_B    = 32'h14000010;
    localparam logic [31:0] W_CB   = 32'hB40000A3;

    instr_encode #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rm_num(rm_num), .rn_num(rn_num), .rd_num(rd_num),
        .shamt(shamt), .address(address), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .instruction(instruction), .wr_addr(wr_addr), .full(full), .err_sticky(err_sticky)
    );

    always #(CYCLE / 2) clk = ~clk;

    task automatic drive(input logic [2:0] f, input logic [10:0] op, input logic [4:0] rm,
                         input logic [4:0] rn, input logic [4:0] rd, input logic [5:0] sh,
                         input logic [8:0] ad, input logic [25:0] im);
        fmt = f; opcode = op; rm_num = rm; rn_num = rn; rd_num = rd; shamt = sh; address = ad; imm = im;
    endtask

    task automatic set_ldur(); drive(3'd2, OP_LDUR, 5'd0, 5'd10, 5'd9, 6'd0, 9'b011110000, 26'd0); endtask
    task automatic set_add();  drive(3'd0, OP_ADD, 5'd9, 5'd21, 5'd9, 6'd0, 9'd0, 26'd0); endtask
    task automatic set_addi(); drive(3'd1, OP_ADDI, 5'd0, 5'd21, 5'd9, 6'd0, 9'd0, 26'd1); endtask

    task automatic tick(); @(posedge clk); #1; endtask

    task automatic do_clear();
        @(negedge clk); in_valid = 1'b0; clear = 1'b1;
        tick();
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_instruction got=%h exp=0", instruction); end
        checks++; if (wr_addr !== 2'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
        checks++; if (full !== 1'b0 || err_sticky !== 1'b0) begin failures++; $display("FAIL reset_flags got full=%b err=%b exp=0/0", full, err_sticky); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_ldur();
        @(negedge clk); set_ldur(); in_valid = 1'b1; out_ready = 1'b1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ldur_in_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || instruction !== W_LDUR) begin failures++; $display("FAIL ldur_word got v=%b %h exp v=1 %h", out_valid, instruction, W_LDUR); end
        checks++; if (wr_addr !== 2'd0) begin failures++; $display("FAIL ldur_addr got=%0d exp=0", wr_addr); end
        @(negedge clk); in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || wr_addr !== 2'd1) begin failures++; $display("FAIL ldur_drain got v=%b a=%0d exp v=0 a=1", out_valid, wr_addr); end
        do_clear();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); set_add(); in_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || instruction !== W_ADD || wr_addr !== 2'd0) begin failures++; $display("FAIL b2b_add got v=%b %h a=%0d exp v=1 %h a=0", out_valid, instruction, wr_addr, W_ADD); end
        @(negedge clk); set_addi();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || instruction !== W_ADDI || wr_addr !== 2'd1) begin failures++; $display("FAIL b2b_addi got v=%b %h a=%0d exp v=1 %h a=1", out_valid, instruction, wr_addr, W_ADDI); end
        @(negedge clk); in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || wr_addr !== 2'd2) begin failures++; $display("FAIL b2b_drain got v=%b a=%0d exp v=0 a=2", out_valid, wr_addr); end
        do_clear();
    endtask

    task automatic test_backpressure();
        @(negedge clk); out_ready = 1'b0; set_add(); in_valid = 1'b1;
        tick();
        @(negedge clk); set_addi();
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || instruction !== W_ADD || wr_addr !== 2'd0) begin failures++; $display("FAIL bp_hold[%0d] got v=%b %h a=%0d exp v=1 %h a=0", i, out_valid, instruction, wr_addr, W_ADD); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || instruction !== W_ADDI || wr_addr !== 2'd1) begin failures++; $display("FAIL bp_release got v=%b %h a=%0d exp v=1 %h a=1", out_valid, instruction, wr_addr, W_ADDI); end
        @(negedge clk); in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || wr_addr !== 2'd2) begin failures++; $display("FAIL bp_drain got v=%b a=%0d exp v=0 a=2", out_valid, wr_addr); end
        do_clear();
    endtask

    task automatic test_branch();
        @(negedge clk); drive(3'd3, 11'b00010111111, 5'd31, 5'd31, 5'd31, 6'd63, 9'h1FF, 26'h0000010); in_valid = 1'b1;
        tick();
        checks++; if (instruction !== W_B) begin failures++; $display("FAIL b_word got=%h exp=%h", instruction, W_B); end
        @(negedge clk); drive(3'd4, 11'b10110100111, 5'd31, 5'd31, 5'd3, 6'd63, 9'h1FF, 26'h3F80005);
        tick();
        checks++; if (instruction !== W_CB || wr_addr !== 2'd1) begin failures++; $display("FAIL cb_word got %h a=%0d exp %h a=1", instruction, wr_addr, W_CB); end
        @(negedge clk); in_valid = 1'b0;
        do_clear();
    endtask

    task automatic test_fill_clear();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_ldur(); rd_num = 5'(i); in_valid = 1'b1;
            tick();
            checks++; if (wr_addr !== 2'(i) || instruction[4:0] !== 5'(i)) begin failures++; $display("FAIL fill_word[%0d] got a=%0d rd=%0d exp a=%0d rd=%0d", i, wr_addr, instruction[4:0], i, i); end
            @(negedge clk); in_valid = 1'b0;
            tick();
        end
        checks++; if (full !== 1'b1 || wr_addr !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL fill_full got full=%b a=%0d v=%b exp 1/0/0", full, wr_addr, out_valid); end
        @(negedge clk); in_valid = 1'b1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_no_accept got v=%b exp=0", out_valid); end
        @(negedge clk); clear = 1'b1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clear_in_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (full !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL clear_state got full=%b v=%b exp 0/0", full, out_valid); end
        @(negedge clk); clear = 1'b0; set_add();
        tick();
        checks++; if (out_valid !== 1'b1 || instruction !== W_ADD || wr_addr !== 2'd0) begin failures++; $display("FAIL post_clear got v=%b %h a=%0d exp v=1 %h a=0", out_valid, instruction, wr_addr, W_ADD); end
        @(negedge clk); in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        @(negedge clk); drive(3'd6, OP_ADD, 5'd1, 5'd1, 5'd1, 6'd1, 9'd1, 26'd1); in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ill_in_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || err_sticky !== 1'b1 || wr_addr !== 2'd1) begin failures++; $display("FAIL ill_effect got v=%b err=%b a=%0d exp v=0 err=1 a=1", out_valid, err_sticky, wr_addr); end
        @(negedge clk); drive(3'd2, OP_STUR, 5'd0, 5'd2, 5'd3, 6'd0, 9'd0, 26'd0);
        tick();
        checks++; if (out_valid !== 1'b1 || instruction !== W_STUR || wr_addr !== 2'd1 || err_sticky !== 1'b1) begin failures++; $display("FAIL stur got v=%b %h a=%0d err=%b exp v=1 %h a=1 err=1", out_valid, instruction, wr_addr, err_sticky, W_STUR); end
        @(negedge clk); in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk); out_ready = 1'b0; set_ldur(); in_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || err_sticky !== 1'b1 || wr_addr !== 2'd2) begin failures++; $display("FAIL stall_pre got v=%b err=%b a=%0d exp v=1 err=1 a=2", out_valid, err_sticky, wr_addr); end
        @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || wr_addr !== 2'd0 || err_sticky !== 1'b0) begin failures++; $display("FAIL stall_reset got v=%b a=%0d err=%b exp 0/0/0", out_valid, wr_addr, err_sticky); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ldur();
        test_back_to_back();
        test_backpressure();
        test_branch();
        test_fill_clear();
        test_illegal();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
